// File: rtl/fnd_pkg.sv
// Shared types, widths and helper functions for the FND scan controller.
package fnd_pkg;

    localparam int CODE_W = 10;
    localparam int SEG_W  = 7;

    localparam logic [SEG_W-1:0] SEG_OFF = 7'h7F;

    typedef enum logic {
        ST_BLANK,
        ST_DRIVE
    } slot_state_e;

    // Active-low {g,f,e,d,c,b,a} pattern for a zero or one-hot digit code.
    function automatic logic [SEG_W-1:0] seg_decode(input logic [CODE_W-1:0] code);
        logic [SEG_W-1:0] segs;
        case (code)
            10'd0:   segs = 7'b1000000;
            10'd1:   segs = 7'b1111001;
            10'd2:   segs = 7'b0100100;
            10'd4:   segs = 7'b0110000;
            10'd8:   segs = 7'b0011001;
            10'd16:  segs = 7'b0010010;
            10'd32:  segs = 7'b0000010;
            10'd64:  segs = 7'b1111000;
            10'd128: segs = 7'b0000000;
            10'd256: segs = 7'b0011000;
            10'd512: segs = 7'b0001000;
            default: segs = SEG_OFF;
        endcase
        return segs;
    endfunction

    // A code is legal when it is zero or has exactly one bit set.
    function automatic logic is_valid_code(input logic [CODE_W-1:0] code);
        return (code & (code - 10'd1)) == '0;
    endfunction

endpackage

// File: rtl/fnd_slot_timer.sv
// Slot sequencer: alternates blanking gaps and digit drive windows, walks the
// digit index and flags the frame boundary.
module fnd_slot_timer
    import fnd_pkg::*;
#(
    parameter int NUM_DIGITS   = 6,
    parameter int TICK_DIV     = 50000,
    parameter int BLANK_CYCLES = 16,
    parameter int IDX_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
    input  logic             clk,
    input  logic             rst_n,
    output slot_state_e      state_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             frame_boundary_o
);

    localparam int MAX_LEN = (TICK_DIV > BLANK_CYCLES) ? TICK_DIV : BLANK_CYCLES;
    localparam int CNT_W   = $clog2(MAX_LEN + 1);

    localparam logic [CNT_W-1:0] TICK_LAST  = CNT_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NUM_DIGITS - 1);

    slot_state_e      state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [IDX_W-1:0] idx_q;

    // Slot FSM: count out each phase, restart the counter on every phase change.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_BLANK;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            case (state_q)
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_q <= ST_DRIVE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                ST_DRIVE: begin
                    if (cnt_q == TICK_LAST) begin
                        state_q <= ST_BLANK;
                        cnt_q   <= '0;
                        idx_q   <= (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_q <= ST_BLANK;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    // The boundary is the last drive cycle of the last digit, i.e. the edge where idx wraps.
    always_comb begin
        frame_boundary_o = (state_q == ST_DRIVE) && (cnt_q == TICK_LAST) && (idx_q == IDX_LAST);
    end

    assign state_o = state_q;
    assign idx_o   = idx_q;

endmodule

// File: rtl/fnd_scan_ctrl.sv
// Multiplexed common-anode FND driver with double-buffered digit codes and
// frame-synchronous bank swap.
module fnd_scan_ctrl
    import fnd_pkg::*;
#(
    parameter int NUM_DIGITS   = 6,
    parameter int TICK_DIV     = 50000,
    parameter int BLANK_CYCLES = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [2:0]            wr_idx,
    input  logic [CODE_W-1:0]     wr_code,
    input  logic                  commit,
    output logic                  wr_ready,
    input  logic                  blank_all,
    output logic [SEG_W-1:0]      seg,
    output logic [NUM_DIGITS-1:0] dig_sel,
    output logic                  err
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [3:0] DIGITS = 4'(NUM_DIGITS);

    slot_state_e      slot_state;
    logic [IDX_W-1:0] slot_idx;
    logic             frame_boundary;

    fnd_slot_timer #(
        .NUM_DIGITS  (NUM_DIGITS),
        .TICK_DIV    (TICK_DIV),
        .BLANK_CYCLES(BLANK_CYCLES),
        .IDX_W       (IDX_W)
    ) u_timer (
        .clk             (clk),
        .rst_n           (rst_n),
        .state_o         (slot_state),
        .idx_o           (slot_idx),
        .frame_boundary_o(frame_boundary)
    );

    logic [CODE_W-1:0]     active_q [NUM_DIGITS];
    logic [CODE_W-1:0]     active_d [NUM_DIGITS];
    logic [CODE_W-1:0]     shadow_q [NUM_DIGITS];
    logic [CODE_W-1:0]     shadow_d [NUM_DIGITS];
    logic                  pending_q, pending_d;
    logic                  wr_ready_q, wr_ready_d;
    logic                  err_q, err_d;
    logic [SEG_W-1:0]      seg_q, seg_d;
    logic [NUM_DIGITS-1:0] dig_sel_q, dig_sel_d;
    logic                  wr_take;
    logic                  wr_good;
    logic [CODE_W-1:0]     cur_code;

    // Host side: shadow writes, error flag, and the commit that waits for a frame boundary.
    always_comb begin
        shadow_d   = shadow_q;
        active_d   = active_q;
        pending_d  = pending_q;
        wr_ready_d = wr_ready_q;
        err_d      = err_q;
        wr_take    = wr_en && wr_ready_q;
        wr_good    = ({1'b0, wr_idx} < DIGITS) && is_valid_code(wr_code);
        if (wr_take) begin
            if (wr_good) begin
                for (int i = 0; i < NUM_DIGITS; i++) begin
                    if (wr_idx == 3'(i)) begin
                        shadow_d[i] = wr_code;
                    end
                end
            end else begin
                err_d = 1'b1;
            end
        end
        if (frame_boundary && pending_q) begin
            active_d   = shadow_q;
            pending_d  = 1'b0;
            wr_ready_d = 1'b1;
        end else if (commit && wr_ready_q) begin
            pending_d  = 1'b1;
            wr_ready_d = 1'b0;
        end
    end

    // Pin side: pick the active code for the current slot and shape the next pin values.
    always_comb begin
        cur_code = '0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (slot_idx == IDX_W'(i)) begin
                cur_code = active_q[i];
            end
        end
        seg_d     = SEG_OFF;
        dig_sel_d = '1;
        if (!blank_all && (slot_state == ST_DRIVE)) begin
            seg_d = seg_decode(cur_code);
            for (int i = 0; i < NUM_DIGITS; i++) begin
                if (slot_idx == IDX_W'(i)) begin
                    dig_sel_d[i] = 1'b0;
                end
            end
        end
    end

    // State and output registers; reset drops any pending commit and darkens the display.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                active_q[i] <= '0;
                shadow_q[i] <= '0;
            end
            pending_q  <= 1'b0;
            wr_ready_q <= 1'b1;
            err_q      <= 1'b0;
            seg_q      <= SEG_OFF;
            dig_sel_q  <= '1;
        end else begin
            for (int i = 0; i < NUM_DIGITS; i++) begin
                active_q[i] <= active_d[i];
                shadow_q[i] <= shadow_d[i];
            end
            pending_q  <= pending_d;
            wr_ready_q <= wr_ready_d;
            err_q      <= err_d;
            seg_q      <= seg_d;
            dig_sel_q  <= dig_sel_d;
        end
    end

    assign wr_ready = wr_ready_q;
    assign err      = err_q;
    assign seg      = seg_q;
    assign dig_sel  = dig_sel_q;

endmodule
